// File: rtl/load_store_unit.sv
// Load/store unit: turns one RV32I byte/half/word request into an aligned 32-bit memory access.
// Latency: load 3 cycles, store 2 cycles, misaligned error 1 cycle (accept edge = cycle 0).
// Backpressure: req_ready is high only in IDLE; the response pulse has no backpressure.
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   req_valid/req_ready         request handshake; req_store, req_funct3, req_addr, req_wdata latched on accept
//   resp_valid/resp_rdata/resp_err  single-cycle completion pulse with extended load data / error flag
//   memAddr/memRstrb/memRData   word-aligned address, read strobe, read data (valid cycle after strobe)
//   memWData/memWMask           lane-replicated write data and byte write enables
//
// Build option: define LSU_MISALIGN_CHECK_EN to enable misalignment detection and the error response.
// Without it resp_err stays 0 and misaligned requests are truncated to the access width's alignment.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] memAddr,
    output logic        memRstrb,
    input  logic [31:0] memRData,
    output logic [31:0] memWData,
    output logic [3:0]  memWMask
);

    typedef enum logic [2:0] {
        IDLE,
        LD_ISSUE,
        LD_CAPTURE,
        ST_ISSUE,
        RESP
    } state_t;

    state_t      state;

    // Load attributes latched on accept, used when the read data returns.
    logic [1:0]  ldWidth;
    logic        ldUnsigned;
    logic [1:0]  ldOffset;

    // Request decode (combinational, only consumed on the accept edge).
    logic        misaligned;
    logic [1:0]  reqOffset;
    logic [31:0] stData;
    logic [3:0]  stMask;

    // Load extraction from the returned word.
    logic [31:0] shifted;
    logic [31:0] ldData;

    always_comb begin
        misaligned = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        case (req_funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            default: misaligned = |req_addr[1:0];
        endcase
`endif
    end

    // Offset bits below the access width are dropped, so an unchecked
    // misaligned request behaves as the aligned access containing it.
    always_comb begin
        reqOffset = 2'b00;
        stData    = req_wdata;
        stMask    = 4'b1111;
        case (req_funct3[1:0])
            2'b00: begin
                reqOffset = req_addr[1:0];
                stData    = {4{req_wdata[7:0]}};
                stMask    = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                reqOffset = {req_addr[1], 1'b0};
                stData    = {2{req_wdata[15:0]}};
                stMask    = 4'b0011 << {req_addr[1], 1'b0};
            end
            default: begin
                reqOffset = 2'b00;
                stData    = req_wdata;
                stMask    = 4'b1111;
            end
        endcase
    end

    always_comb begin
        shifted = memRData >> {ldOffset, 3'b000};
        case (ldWidth)
            2'b00:   ldData = ldUnsigned ? {24'h0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   ldData = ldUnsigned ? {16'h0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            default: ldData = memRData;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            memAddr    <= 32'h0;
            memRstrb   <= 1'b0;
            memWData   <= 32'h0;
            memWMask   <= 4'h0;
            ldWidth    <= 2'b00;
            ldUnsigned <= 1'b0;
            ldOffset   <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready  <= 1'b0;
                        resp_rdata <= 32'h0;
                        resp_err   <= 1'b0;
                        if (misaligned) begin
                            // No memory access; memAddr keeps its previous value.
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            state      <= RESP;
                        end else if (req_store) begin
                            memAddr  <= {req_addr[31:2], 2'b00};
                            memWData <= stData;
                            memWMask <= stMask;
                            state    <= ST_ISSUE;
                        end else begin
                            memAddr    <= {req_addr[31:2], 2'b00};
                            memRstrb   <= 1'b1;
                            ldWidth    <= req_funct3[1:0];
                            ldUnsigned <= req_funct3[2];
                            ldOffset   <= reqOffset;
                            state      <= LD_ISSUE;
                        end
                    end
                end
                LD_ISSUE: begin
                    memRstrb <= 1'b0;
                    state    <= LD_CAPTURE;
                end
                LD_CAPTURE: begin
                    resp_rdata <= ldData;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                ST_ISSUE: begin
                    memWMask   <= 4'h0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the core's execute stage and the word-addressed data memory (`memAddr`/`memRstrb`/`memRData`/`memWData`/`memWMask` bus, 1-cycle registered read, byte-masked write). It accepts one RV32I load or store request at a time and converts byte/halfword/word accesses into aligned 32-bit memory transactions. For loads it extracts and sign- or zero-extends the returned data; for stores it replicates the data and generates the byte mask. Each request completes with a single-cycle response pulse.

## Interface
- No parameters. Data and address width are fixed at 32 bits.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present; accepted when `req_valid && req_ready`.
- `req_ready`  out  1  high only in IDLE.
- `req_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3 field. `[1:0]` is the width: 00 byte, 01 half, 10 word, 11 treated as word. `[2]` is the unsigned-load flag and is ignored for stores.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned access; qualified by `resp_valid`.
- `memAddr`  out  32  memory byte address; low 2 bits forced to 0.
- `memRstrb`  out  1  read strobe.
- `memRData`  in  32  read data, valid the cycle after `memRstrb`.
- `memWData`  out  32  write data, lane-replicated.
- `memWMask`  out  4  byte write enables.

## Operation
- FSM states:
  - IDLE: the only state that accepts a request.
  - LD_ISSUE: drives `memRstrb`.
  - LD_CAPTURE: extracts and extends `memRData` into the `resp_rdata` register.
  - ST_ISSUE: drives the write mask.
  - RESP: asserts `resp_valid`.
- Transitions:
  - IDLE→LD_ISSUE on an accepted load.
  - IDLE→ST_ISSUE on an accepted store.
  - IDLE→RESP on an accepted misaligned request (with checking compiled in).
  - LD_ISSUE→LD_CAPTURE, LD_CAPTURE→RESP, ST_ISSUE→RESP, RESP→IDLE, each unconditionally.
- The request fields are latched on accept; inputs are ignored while busy.
- All memory-side and response outputs are registered.
- Outside LD_ISSUE `memRstrb`=0; outside ST_ISSUE `memWMask`=0. `memAddr` holds its last value while idle.
- Store lanes (o = `addr[1:0]`):
  - Byte: `memWData`={4{wdata[7:0]}}, mask=4'b0001<<o.
  - Half: {2{wdata[15:0]}}, mask=4'b0011<<{o[1],1'b0}.
  - Word: wdata, mask=4'b1111.
- Load extraction:
  - Shift `memRData` right by 8*o (halfword uses o[1]).
  - Sign-extend from bit 7/15 when `funct3[2]`=0, otherwise zero-extend.
  - Word loads pass through unchanged.
- Misaligned means a halfword with `addr[0]`=1, or a word with `addr[1:0]`≠0. No memory access is made; RESP is reached with `resp_err`=1 and `resp_rdata`=0.
- Reset clears the state to IDLE. Reset values: `req_ready`=1, and `resp_valid`, `resp_err`, `resp_rdata`, `memAddr`, `memRstrb`, `memWData`, `memWMask` all 0.
- Reset during any busy state aborts the request with no response.
  - A store whose mask is already asserted in the reset cycle still writes at that edge, because memory samples the pre-reset mask.
  - An aborted load's `memRData` is discarded.

## Timing
- Cycle 0 is the accept edge.
- Load: `memRstrb` high in cycle 1; data captured at the end of cycle 2; `resp_valid` in cycle 3. Latency 3, throughput one load per 4 cycles.
- Store: mask high in cycle 1, and memory writes at the end of cycle 1; `resp_valid` in cycle 2. Latency 2, throughput one store per 3 cycles.
- Misaligned: `resp_valid` in cycle 1.
- `req_ready` falls the cycle after accept and rises the cycle after `resp_valid`. No request is accepted in the same cycle as `resp_valid`.
- The response has no backpressure; the consumer must sample it in the pulse cycle.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined: the misalignment detection and error path are as above.
- Undefined:
  - `resp_err` is tied to 0.
  - Low address bits beyond the access width are ignored: half uses `addr[1]` only, word uses no offset.
  - Misaligned requests proceed as aligned accesses with normal latency.

## Test plan
- LB at 0x5 with word 0x80FF7F01 at 0x4 → `memAddr`=0x4, `memRstrb` pulse in cycle 1, `resp_valid` in cycle 3, `resp_rdata`=0x0000007F.
- Same word: LB 0x6 → 0xFFFFFFFF; LBU 0x6 → 0x000000FF; LH 0x6 → 0xFFFF80FF; LHU 0x6 → 0x000080FF; LW 0x4 → 0x80FF7F01.
- SB 0xB with wdata 0x12345678 → cycle 1 `memWMask`=4'b1000, `memWData`=0x78787878. SH 0x6 → mask 4'b1100, data 0x56785678. Read-back LW 0x8 shows only the targeted bytes changed; `resp_valid` in cycle 2.
- With the macro defined, LW 0x6 → `resp_valid` with `resp_err`=1 in cycle 1, `resp_rdata`=0, no `memRstrb`/`memWMask` activity. Without the macro → normal load of word 0x4.
- Back-to-back: hold `req_valid` high with two loads → second accepted exactly 4 cycles after the first, `req_ready` low in between.
- Assert `reset` in cycle 2 of a load → IDLE next cycle, no `resp_valid`, all outputs at reset values, and a following store completes normally.
